// File: rtl/map_loader.sv
// Writes the 160x90 4-bit palette map RAM from a packed byte stream (two pixels per byte) or a solid-colour fill.
// Latency: a write appears one cycle after its byte handshake (low nibble) and the cycle after that (high nibble); fill writes one pixel per cycle.
// Backpressure: data_ready_out is high only in LOAD phase 0, so at most one byte every two cycles is accepted; bytes outside LOAD are never consumed.
module map_loader #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 90,
    parameter int PIX_BITS = 4
) (
    input  logic                              pixel_clk_in,
    input  logic                              rst_in,
    input  logic                              start_in,
    input  logic                              fill_in,
    input  logic [PIX_BITS-1:0]               fill_color_in,
    input  logic                              abort_in,
    input  logic [7:0]                        data_in,
    input  logic                              data_valid_in,
    output logic                              data_ready_out,
    output logic                              wr_en_out,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   wr_addr_out,
    output logic [PIX_BITS-1:0]               wr_data_out,
    output logic                              busy_out,
    output logic                              done_out
);

    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int ADDR_W = $clog2(NPIX);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                phase_q, phase_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [PIX_BITS-1:0] color_q, color_d;
    logic [PIX_BITS-1:0] hold_q, hold_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [PIX_BITS-1:0] wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Ready is combinational so the upstream sees it in the same cycle as the state it depends on.
    assign data_ready_out = (state_q == S_LOAD) && !phase_q;
    assign wr_en_out      = wr_en_q;
    assign wr_addr_out    = wr_addr_q;
    assign wr_data_out    = wr_data_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;

    // State, counters and registered outputs; reset returns everything to zero/IDLE immediately.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            cnt_q     <= '0;
            color_q   <= '0;
            hold_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            color_q   <= color_d;
            hold_q    <= hold_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and next-output decode; write enable and done default low so they only pulse when issued.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        color_d   = color_q;
        hold_d    = hold_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Fill takes priority so a clear cannot be lost to a coincident load request.
                if (fill_in) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    color_d = fill_color_in;
                end else if (start_in) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
            end

            S_FILL: begin
                if (abort_in) begin
                    state_d = S_IDLE;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = color_q;
                    cnt_d     = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_LOAD: begin
                if (abort_in) begin
                    // Any held high nibble is simply discarded.
                    state_d = S_IDLE;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                end else if (phase_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = hold_q;
                    cnt_d     = cnt_q + ADDR_W'(1);
                    phase_d   = 1'b0;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end
                end else if (data_valid_in) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = PIX_BITS'(data_in[3:0]);
                    hold_d    = PIX_BITS'(data_in[7:4]);
                    cnt_d     = cnt_q + ADDR_W'(1);
                    phase_d   = 1'b1;
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_FILL);
    end

endmodule

// File: tb/tb_map_loader.sv
module tb_map_loader;

    localparam int W      = 160;
    localparam int H      = 90;
    localparam int NPIX   = W * H;
    localparam int NBYTES = NPIX / 2;
    localparam int AW     = $clog2(NPIX);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_in = 1'b0;
    logic          fill_in = 1'b0;
    logic [3:0]    fill_color_in = 4'h0;
    logic          abort_in = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          data_valid_in = 1'b0;
    logic          data_ready_out;
    logic          wr_en_out;
    logic [AW-1:0] wr_addr_out;
    logic [3:0]    wr_data_out;
    logic          busy_out;
    logic          done_out;

    int errors = 0;
    int checks = 0;

    map_loader #(.WIDTH(W), .HEIGHT(H), .PIX_BITS(4)) dut (
        .pixel_clk_in  (clk),
        .rst_in        (rst),
        .start_in      (start_in),
        .fill_in       (fill_in),
        .fill_color_in (fill_color_in),
        .abort_in      (abort_in),
        .data_in       (data_in),
        .data_valid_in (data_valid_in),
        .data_ready_out(data_ready_out),
        .wr_en_out     (wr_en_out),
        .wr_addr_out   (wr_addr_out),
        .wr_data_out   (wr_data_out),
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    always #5 clk = ~clk;

    // Observation log, sampled mid-cycle on the falling edge.
    int   cyc = 0;
    int   wa_q[$];
    int   wd_q[$];
    int   wc_q[$];
    int   done_q[$];
    int   hs_cnt = 0;
    int   busy_cnt = 0;
    logic [7:0] tx_bytes[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_en_out === 1'b1) begin
            wa_q.push_back(int'(wr_addr_out));
            wd_q.push_back(int'(wr_data_out));
            wc_q.push_back(cyc);
        end
        if (done_out === 1'b1) done_q.push_back(cyc);
        if (data_valid_in && data_ready_out === 1'b1) hs_cnt = hs_cnt + 1;
        if (busy_out === 1'b1) busy_cnt = busy_cnt + 1;
    end

    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_q.delete();
        hs_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        step(1);
        start_in = 1'b0;
    endtask

    task automatic pulse_abort();
        abort_in = 1'b1;
        step(1);
        abort_in = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            step(1);
            n++;
        end
        ok = (done_q.size() != 0);
    endtask

    // Offer tx_bytes[0..n-1] in order; valid drops randomly with probability gap/100.
    task automatic drive_load(input int n, input int gap, output bit ok);
        int idx = 0;
        int budget = n * 20 + 100;
        bit fire;
        while (idx < n && budget > 0) begin
            data_in       = tx_bytes[idx];
            data_valid_in = ($urandom_range(99) >= gap);
            @(negedge clk);
            fire = data_valid_in && (data_ready_out === 1'b1);
            step(1);
            if (fire) idx++;
            budget--;
        end
        ok = (idx == n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, data_ready_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b addr=%0d data=%0d busy=%b done=%b rdy=%b, want all 0",
                     wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, data_ready_out);
        end
        step(1);
        rst = 1'b0;
        step(2);
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy_out, done_out);
        end
    endtask

    task automatic test_fill();
        bit ok;
        int bad = 0;
        int gaps = 0;
        clear_logs();
        fill_in = 1'b1;
        fill_color_in = 4'h2;
        step(1);
        fill_in = 1'b0;
        fill_color_in = 4'hF;
        wait_done(NPIX + 1000, ok);
        step(5);
        checks++;
        if (!ok) begin errors++; $display("FAIL fill_timeout: no done_out, want one"); end
        checks++;
        if (wa_q.size() != NPIX) begin
            errors++; $display("FAIL fill_count: got %0d writes, want %0d", wa_q.size(), NPIX);
        end
        for (int i = 0; i < wa_q.size(); i++) begin
            if (wa_q[i] != i || wd_q[i] != 2) bad++;
            if (i > 0 && wc_q[i] != wc_q[i-1] + 1) gaps++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL fill_data: got %0d bad writes, want 0", bad); end
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL fill_gaps: got %0d gaps, want 0", gaps); end
        checks++;
        if (busy_cnt != NPIX) begin
            errors++; $display("FAIL fill_busy: got %0d busy cycles, want %0d", busy_cnt, NPIX);
        end
        checks++;
        if (done_q.size() != 1 || wc_q.size() == 0 || done_q[0] != wc_q[wc_q.size()-1] + 1) begin
            errors++;
            $display("FAIL fill_done: got %0d pulses first@%0d lastwr@%0d, want 1 at lastwr+1",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1,
                     (wc_q.size() > 0) ? wc_q[wc_q.size()-1] : -1);
        end
    endtask

    task automatic test_reset_midfill();
        int n = 0;
        bit found = 0;
        bit ok;
        clear_logs();
        fill_in = 1'b1;
        fill_color_in = 4'h7;
        step(1);
        fill_in = 1'b0;
        while (!found && n < 1000) begin
            @(negedge clk);
            if (wr_en_out === 1'b1 && wr_addr_out == AW'(500)) found = 1;
            n++;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midfill_reach: address 500 not seen"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, data_ready_out} !== '0) begin
            errors++;
            $display("FAIL midfill_async: got en=%b addr=%0d data=%0d busy=%b done=%b rdy=%b, want all 0",
                     wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, data_ready_out);
        end
        step(2);
        rst = 1'b0;
        step(1);
        clear_logs();
        pulse_start();
        tx_bytes.delete();
        tx_bytes.push_back(8'hA5);
        drive_load(1, 0, ok);
        data_valid_in = 1'b0;
        step(3);
        checks++;
        if (!ok || wa_q.size() != 2 || wa_q[0] != 0 || wd_q[0] != 5 || wa_q[1] != 1 || wd_q[1] != 10) begin
            errors++;
            $display("FAIL post_reset_load: got %0d writes first=%0d/%0d, want 2 writes 0/5 1/10",
                     wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : -1, (wd_q.size() > 0) ? wd_q[0] : -1);
        end
        checks++;
        if (done_q.size() != 0) begin errors++; $display("FAIL midfill_done: got %0d, want 0", done_q.size()); end
        pulse_abort();
        step(2);
    endtask

    task automatic test_basic_load();
        logic [7:0] b [2];
        logic [3:0] rdy;
        int bad = 0;
        b[0] = 8'h10;
        b[1] = 8'h32;
        clear_logs();
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            data_in = b[k/2];
            data_valid_in = 1'b1;
            @(negedge clk);
            rdy[3-k] = data_ready_out;
            step(1);
        end
        data_valid_in = 1'b0;
        step(3);
        checks++;
        if (rdy !== 4'b1010) begin errors++; $display("FAIL basic_ready: got %b, want 1010", rdy); end
        checks++;
        if (hs_cnt != 2) begin errors++; $display("FAIL basic_hs: got %0d, want 2", hs_cnt); end
        for (int i = 0; i < 4; i++) if (i >= wa_q.size() || wa_q[i] != i || wd_q[i] != i) bad++;
        checks++;
        if (bad != 0 || wa_q.size() != 4) begin
            errors++; $display("FAIL basic_writes: got %0d writes %0d bad, want 4 writes 0 bad", wa_q.size(), bad);
        end
        pulse_abort();
        @(negedge clk);
        checks++;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL basic_abort_busy: got %b, want 0", busy_out); end
        step(1);
    endtask

    task automatic test_backpressure();
        bit ok, ok2;
        int bad = 0;
        int exp_d;
        clear_logs();
        tx_bytes.delete();
        for (int i = 0; i < NBYTES; i++) tx_bytes.push_back(8'($urandom));
        pulse_start();
        drive_load(NBYTES, 40, ok);
        data_in = 8'hEE;
        data_valid_in = 1'b1;
        step(20);
        data_valid_in = 1'b0;
        wait_done(100, ok2);
        step(3);
        checks++;
        if (!ok || !ok2) begin errors++; $display("FAIL bp_timeout: drive=%b done=%b, want 1 1", ok, ok2); end
        checks++;
        if (hs_cnt != NBYTES) begin errors++; $display("FAIL bp_handshakes: got %0d, want %0d", hs_cnt, NBYTES); end
        checks++;
        if (wa_q.size() != NPIX) begin errors++; $display("FAIL bp_count: got %0d, want %0d", wa_q.size(), NPIX); end
        for (int i = 0; i < wa_q.size() && i < NPIX; i++) begin
            exp_d = (i % 2 == 0) ? int'(tx_bytes[i/2] & 8'h0F) : int'(tx_bytes[i/2] >> 4);
            if (wa_q[i] != i || wd_q[i] != exp_d) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_data: got %0d bad writes, want 0", bad); end
        checks++;
        if (done_q.size() != 1) begin errors++; $display("FAIL bp_done: got %0d pulses, want 1", done_q.size()); end
    endtask

    task automatic test_abort();
        bit ok;
        int saw201 = 0;
        clear_logs();
        tx_bytes.delete();
        for (int i = 0; i < 101; i++) tx_bytes.push_back(8'($urandom));
        pulse_start();
        drive_load(101, 0, ok);
        data_valid_in = 1'b0;
        pulse_abort();
        @(negedge clk);
        checks++;
        if (busy_out !== 1'b0 || data_ready_out !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b rdy=%b, want 0 0", busy_out, data_ready_out);
        end
        step(10);
        foreach (wa_q[i]) if (wa_q[i] == 201) saw201++;
        checks++;
        if (!ok || saw201 != 0 || wa_q.size() != 201) begin
            errors++; $display("FAIL abort_writes: got %0d writes, addr201 seen %0d, want 201 and 0", wa_q.size(), saw201);
        end
        checks++;
        if (done_q.size() != 0) begin errors++; $display("FAIL abort_done: got %0d, want 0", done_q.size()); end
        clear_logs();
        tx_bytes.delete();
        tx_bytes.push_back(8'h3C);
        pulse_start();
        drive_load(1, 0, ok);
        data_valid_in = 1'b0;
        step(3);
        checks++;
        if (!ok || wa_q.size() != 2 || wa_q[0] != 0 || wd_q[0] != 12 || wa_q[1] != 1 || wd_q[1] != 3) begin
            errors++;
            $display("FAIL abort_restart: got %0d writes first addr %0d, want 2 writes from addr 0",
                     wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : -1);
        end
        pulse_abort();
        step(2);
    endtask

    task automatic test_priority();
        bit ok;
        int bad = 0;
        clear_logs();
        start_in = 1'b1;
        fill_in = 1'b1;
        fill_color_in = 4'h9;
        step(1);
        start_in = 1'b0;
        fill_in = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_out !== 1'b1 || data_ready_out !== 1'b0) begin
            errors++; $display("FAIL prio_fill: busy=%b rdy=%b, want 1 0", busy_out, data_ready_out);
        end
        step(100);
        pulse_start();
        wait_done(NPIX + 1000, ok);
        step(20);
        foreach (wd_q[i]) if (wd_q[i] != 9) bad++;
        checks++;
        if (!ok || wa_q.size() != NPIX || bad != 0) begin
            errors++; $display("FAIL prio_writes: got %0d writes %0d bad, want %0d and 0", wa_q.size(), bad, NPIX);
        end
        checks++;
        if (busy_cnt != NPIX || done_q.size() != 1) begin
            errors++; $display("FAIL prio_no_load: busy cycles %0d done %0d, want %0d and 1", busy_cnt, done_q.size(), NPIX);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_reset_midfill();
        test_basic_load();
        test_backpressure();
        test_abort();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
